// File: rtl/act_pkg.sv
// Shared types and constants for the multi-lane activation pipeline.
package act_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_LEAKY  = 2'd2,
        ACT_CLIP   = 2'd3
    } act_mode_e;

    localparam int SAT_CNT_W = 16;
    localparam logic [SAT_CNT_W-1:0] SAT_CNT_MAX = '1;

endpackage

// File: rtl/act_rescale.sv
// Single-lane Q-format conversion: round-half-up on right shift, saturate to N bits.
// Purely combinational; no handshake.
module act_rescale #(
    parameter int M      = 8,
    parameter int X_FRAC = 5,
    parameter int N      = 8,
    parameter int Y_FRAC = 5
) (
    input  logic [M-1:0] a_i,
    output logic [N-1:0] r_o,
    output logic         sat_o
);

    localparam int D   = X_FRAC - Y_FRAC;
    localparam int LSH = (D < 0) ? -D : 0;
    // Wide enough that neither the rounding add nor a left shift can wrap.
    localparam int W   = M + LSH + N + 2;
    localparam logic signed [W-1:0] MAX_V = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};

    logic signed [W-1:0] a_ext;
    logic signed [W-1:0] r_w;

    assign a_ext = W'($signed(a_i));

    generate
        if (D > 0) begin : g_rnd
            localparam logic signed [W-1:0] HALF = W'(1) <<< (D - 1);
            assign r_w = (a_ext + HALF) >>> D;
        end else begin : g_shl
            assign r_w = a_ext <<< LSH;
        end
    endgenerate

    always_comb begin
        r_o   = r_w[N-1:0];
        sat_o = 1'b0;
        if (r_w > MAX_V) begin
            r_o   = MAX_V[N-1:0];
            sat_o = 1'b1;
        end else if (r_w < MIN_V) begin
            r_o   = MIN_V[N-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/act_pipe.sv
// Multi-lane activation + Q-format conversion, 2-cycle latency, 1 beat/cycle.
// Backpressure: each stage loads when empty or draining; holds output stable while out_ready is low.
module act_pipe
    import act_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int X_INT      = 3,
    parameter int X_FRAC     = 5,
    parameter int Y_INT      = 3,
    parameter int Y_FRAC     = 5,
    parameter int LEAK_SHIFT = 3,
    parameter int CLIP       = 'h20,
    localparam int M         = X_INT + X_FRAC,
    localparam int N         = Y_INT + Y_FRAC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [LANES*M-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*N-1:0]   out_data,
    output logic                 out_sat,
    input  logic                 sat_clr,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam logic signed [M-1:0] CLIP_V = CLIP[M-1:0];

    function automatic logic [M-1:0] act_lane(input logic [M-1:0] x, input act_mode_e m);
        logic signed [M-1:0] xs;
        logic [M-1:0]        leak;
        xs   = $signed(x);
        leak = xs >>> LEAK_SHIFT;
        case (m)
            ACT_RELU:  act_lane = xs[M-1] ? '0 : x;
            ACT_LEAKY: act_lane = xs[M-1] ? leak : x;
            ACT_CLIP:  act_lane = xs[M-1] ? '0 : ((xs > CLIP_V) ? CLIP_V : x);
            default:   act_lane = x;
        endcase
    endfunction

    act_mode_e              mode_w;
    logic [LANES*M-1:0]     act_w;
    logic [LANES*N-1:0]     resc_w;
    logic [LANES-1:0]       lane_sat;
    logic                   s2_adv;

    logic                   s1_vld_q, s1_vld_d;
    logic [LANES*M-1:0]     s1_act_q, s1_act_d;
    logic                   s2_vld_q, s2_vld_d;
    logic [LANES*N-1:0]     s2_dat_q, s2_dat_d;
    logic                   s2_sat_q, s2_sat_d;
    logic [SAT_CNT_W-1:0]   sat_cnt_q, sat_cnt_d;

    assign mode_w = act_mode_e'(in_mode);

    always_comb begin
        act_w = '0;
        for (int i = 0; i < LANES; i++) begin
            act_w[i*M +: M] = act_lane(in_data[i*M +: M], mode_w);
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            act_rescale #(
                .M      (M),
                .X_FRAC (X_FRAC),
                .N      (N),
                .Y_FRAC (Y_FRAC)
            ) u_rescale (
                .a_i   (s1_act_q[g*M +: M]),
                .r_o   (resc_w[g*N +: N]),
                .sat_o (lane_sat[g])
            );
        end
    endgenerate

    // in_ready depends on out_ready only, never on in_valid.
    assign s2_adv   = out_ready | ~s2_vld_q;
    assign in_ready = ~s1_vld_q | s2_adv;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_act_d  = s1_act_q;
        s2_vld_d  = s2_vld_q;
        s2_dat_d  = s2_dat_q;
        s2_sat_d  = s2_sat_q;
        sat_cnt_d = sat_cnt_q;

        if (in_ready) begin
            s1_vld_d = in_valid;
            if (in_valid) s1_act_d = act_w;
        end

        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_dat_d = resc_w;
                s2_sat_d = |lane_sat;
            end
        end

        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (s2_vld_q && out_ready && s2_sat_q && (sat_cnt_q != SAT_CNT_MAX)) begin
            sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_act_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_dat_q  <= '0;
            s2_sat_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_act_q  <= s1_act_d;
            s2_vld_q  <= s2_vld_d;
            s2_dat_q  <= s2_dat_d;
            s2_sat_q  <= s2_sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_data  = s2_dat_q;
    assign out_sat   = s2_sat_q;
    assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_act_pipe.sv
// Bench for act_pipe: default-format instance plus a Q2.3-output instance sharing one stimulus stream.
module tb_act_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_mode;
    logic [31:0] in_data;
    logic        out_ready;
    logic        sat_clr;

    logic        in_ready_a, out_valid_a, out_sat_a;
    logic [31:0] out_data_a;
    logic [15:0] sat_count_a;
    logic        in_ready_b, out_valid_b, out_sat_b;
    logic [19:0] out_data_b;
    logic [15:0] sat_count_b;

    always #5 clk = ~clk;

    act_pipe dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a),
        .out_sat   (out_sat_a),
        .sat_clr   (sat_clr),
        .sat_count (sat_count_a)
    );

    act_pipe #(.Y_INT(2), .Y_FRAC(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_data  (out_data_b),
        .out_sat   (out_sat_b),
        .sat_clr   (sat_clr),
        .sat_count (sat_count_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int fdiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int act_ref(input int x, input int mode);
        case (mode)
            0: return x;
            1: return (x < 0) ? 0 : x;
            2: return (x < 0) ? fdiv(x, 8) : x;
            default: begin
                if (x < 0) return 0;
                if (x > 32) return 32;
                return x;
            end
        endcase
    endfunction

    function automatic int resc_ref(input int a, input int xf, input int yf, input int n,
                                    output bit sat);
        int d, r, hi, lo;
        d  = xf - yf;
        r  = (d > 0) ? fdiv(a + (1 << (d - 1)), 1 << d) : a * (1 << (-d));
        hi = (1 << (n - 1)) - 1;
        lo = -(1 << (n - 1));
        sat = 1'b0;
        if (r > hi) begin r = hi; sat = 1'b1; end
        if (r < lo) begin r = lo; sat = 1'b1; end
        return r;
    endfunction

    typedef struct {
        logic [31:0] da;
        logic [19:0] db;
        bit          sa;
        bit          sb;
        int          t;
    } exp_t;

    function automatic exp_t model(input logic [1:0] mode, input logic [31:0] d, input int t);
        exp_t e;
        int   x, a, ra, rb;
        bit   s;
        e.da = '0; e.db = '0; e.sa = 1'b0; e.sb = 1'b0; e.t = t;
        for (int i = 0; i < 4; i++) begin
            x  = $signed(d[i*8 +: 8]);
            a  = act_ref(x, int'(mode));
            ra = resc_ref(a, 5, 5, 8, s);
            e.da[i*8 +: 8] = ra[7:0];
            e.sa = e.sa | s;
            rb = resc_ref(a, 5, 3, 5, s);
            e.db[i*5 +: 5] = rb[4:0];
            e.sb = e.sb | s;
        end
        return e;
    endfunction

    // ---------------- scoreboard monitor (samples on falling edge) ----------------
    exp_t q[$];
    exp_t f;
    int   cyc = 0;
    int   sat_ma = 0, sat_mb = 0;
    bit   exp_rdy, exp_vld, xfer_out;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            sat_ma = 0;
            sat_mb = 0;
            chk("rst_out_valid_a", 32'(out_valid_a), 0);
            chk("rst_out_valid_b", 32'(out_valid_b), 0);
            chk("rst_out_data_a", out_data_a, 0);
            chk("rst_out_sat_a", 32'(out_sat_a), 0);
            chk("rst_sat_count_a", 32'(sat_count_a), 0);
            chk("rst_sat_count_b", 32'(sat_count_b), 0);
        end else begin
            exp_rdy = (q.size() < 2) || out_ready;
            exp_vld = (q.size() > 0) && (cyc - q[0].t >= 2);
            chk("in_ready_a", 32'(in_ready_a), 32'(exp_rdy));
            chk("in_ready_b", 32'(in_ready_b), 32'(exp_rdy));
            chk("out_valid_a", 32'(out_valid_a), 32'(exp_vld));
            chk("out_valid_b", 32'(out_valid_b), 32'(exp_vld));
            if (exp_vld) begin
                f = q[0];
                chk("out_data_a", out_data_a, f.da);
                chk("out_data_b", 32'(out_data_b), 32'(f.db));
                chk("out_sat_a", 32'(out_sat_a), 32'(f.sa));
                chk("out_sat_b", 32'(out_sat_b), 32'(f.sb));
            end
            chk("sat_count_a", 32'(sat_count_a), 32'(sat_ma));
            chk("sat_count_b", 32'(sat_count_b), 32'(sat_mb));
            xfer_out = exp_vld && out_ready;
            if (sat_clr) begin
                sat_ma = 0;
                sat_mb = 0;
            end else if (xfer_out) begin
                if (f.sa && sat_ma < 65535) sat_ma++;
                if (f.sb && sat_mb < 65535) sat_mb++;
            end
            if (xfer_out) void'(q.pop_front());
            if (in_valid && exp_rdy) q.push_back(model(in_mode, in_data, cyc));
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    bit rdy_rand = 1'b0;

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ok = in_ready_a;
            step();
            if (ok) break;
        end
        in_valid = 1'b0;
        chk("send_accept", 32'(ok), 1);
    endtask

    // Send into an empty pipe with out_ready high; return at the falling edge where the beat is on the output.
    task automatic probe(input logic [1:0] m, input logic [31:0] d);
        send(m, d);
        @(negedge clk);
        chk("probe_not_early", 32'(out_valid_a), 0);
        @(negedge clk);
        chk("probe_lat2_valid", 32'(out_valid_a), 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) step();
    endtask

    logic [1:0]  bm [4];
    logic [31:0] bd [4];
    logic        acc;
    int          k;

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_data = '0;
        out_ready = 1'b1; sat_clr = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready_a), 1);
        step();

        // directed test-plan vectors
        probe(2'd1, 32'h0000_D030);
        chk("relu_lane0", 32'(out_data_a[7:0]), 32'h30);
        chk("relu_lane1", 32'(out_data_a[15:8]), 32'h00);
        chk("relu_sat", 32'(out_sat_a), 0);
        step();
        probe(2'd2, 32'h0000_00D0);
        chk("leaky_neg", 32'(out_data_a[7:0]), 32'hFA);
        step();
        probe(2'd3, 32'h0000_E030);
        chk("clip_ceiling", 32'(out_data_a[7:0]), 32'h20);
        chk("clip_neg", 32'(out_data_a[15:8]), 32'h00);
        step();
        probe(2'd0, 32'h0000_0030);
        chk("q23_bypass", 32'(out_data_b[4:0]), 32'h0C);
        step();
        probe(2'd0, 32'h807F_FE02);
        chk("q23_round_sat", 32'(out_data_b), 32'({5'h10, 5'h0F, 5'h00, 5'h01}));
        chk("q23_out_sat", 32'(out_sat_b), 1);
        chk("satcnt_before", 32'(sat_count_b), 0);
        @(negedge clk);
        chk("satcnt_after", 32'(sat_count_b), 1);
        step();

        // full pipe with downstream stalled
        for (int i = 0; i < 4; i++) begin
            bm[i] = 2'($urandom_range(0, 3));
            bd[i] = $urandom();
        end
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_mode  = bm[k];
            in_data  = bd[k];
            @(negedge clk);
            acc = in_ready_a;
            if (c == 5) chk("full_in_ready", 32'(in_ready_a), 0);
            step();
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("full_accepted", 32'(k), 2);
        out_ready = 1'b1;
        for (int j = k; j < 4; j++) send(bm[j], bd[j]);
        drain();

        // randomized traffic with random backpressure and occasional clears
        rdy_rand = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            sat_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) step();
            send(2'($urandom_range(0, 3)), $urandom());
        end
        sat_clr  = 1'b0;
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        drain();

        // drive the counter to its ceiling and past it
        in_valid = 1'b1;
        in_mode  = 2'd0;
        in_data  = 32'h7F7F_7F7F;
        repeat (65540) step();
        in_valid = 1'b0;
        drain();
        @(negedge clk);
        chk("satcnt_hold", 32'(sat_count_b), 32'hFFFF);
        step();

        // clear coincides with a saturating transfer
        send(2'd0, 32'h0000_007F);
        step();
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        @(negedge clk);
        chk("satclr_wins", 32'(sat_count_b), 0);
        step();

        // reset with both stages occupied
        out_ready = 1'b0;
        send(2'd0, 32'h1111_1111);
        send(2'd0, 32'h2222_2222);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid_a), 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        probe(2'd1, 32'h0000_0030);
        chk("rst_first_beat", out_data_a, 32'h0000_0030);
        step();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
